jtag_tap_ctrl: RTL and testbench

//  Full IEEE 1149.1 TAP controller: all 16 TAP states, parametrised instruction register,

---
 rtl/jtag_tap_ctrl.sv | 151 +++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with a parametrised IR, IDCODE / BYPASS / USER data registers
// and a registered TDI->TDO serial path. Everything lives in the TCK (clk) domain.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter int          USER_WIDTH = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          IDCODE_OP  = 1,
  parameter int          USER_OP    = 2
) (
  input  logic                  clk,
  input  logic                  TRST,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  tdo_en,
  output logic [3:0]            state_obs,
  output logic [IR_WIDTH-1:0]   ir_out,
  output logic [USER_WIDTH-1:0] user_dr,
  output logic                  update_pulse
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] IDCODE_IR  = IR_WIDTH'(IDCODE_OP);
  localparam logic [IR_WIDTH-1:0] USER_IR    = IR_WIDTH'(USER_OP);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_t            state, state_nxt;
  logic [IR_WIDTH-1:0]   ir_sr, ir_sr_nxt;
  logic [31:0]           id_sr, id_sr_nxt;
  logic [USER_WIDTH-1:0] user_sr, user_sr_nxt;
  logic                  byp_sr, byp_nxt;
  logic                  tdo_nxt;
  logic                  sel_id, sel_user;

  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    case (s)
      TLR:     next_state = tms ? TLR    : RTI;
      RTI:     next_state = tms ? SEL_DR : RTI;
      SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms ? SEL_DR : RTI;
      SEL_IR:  next_state = tms ? TLR    : CAP_IR;
      CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
      UPD_IR:  next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  endfunction

  // IDCODE wins if both opcodes alias; any unknown opcode falls through to BYPASS.
  assign sel_id   = (ir_out == IDCODE_IR);
  assign sel_user = (ir_out == USER_IR) && !sel_id;

  // Shift-register next values; TDO looks at these so it shows the bit as it stands after the edge.
  always_comb begin
    state_nxt   = next_state(state, TMS);
    ir_sr_nxt   = ir_sr;
    id_sr_nxt   = id_sr;
    user_sr_nxt = user_sr;
    byp_nxt     = byp_sr;
    case (state)
      CAP_IR: ir_sr_nxt = IR_CAPTURE;
      SH_IR: begin
        ir_sr_nxt               = ir_sr >> 1;
        ir_sr_nxt[IR_WIDTH-1]   = TDI;
      end
      CAP_DR: begin
        if (sel_id)        id_sr_nxt   = IDCODE_VAL;
        else if (sel_user) user_sr_nxt = user_dr;
        else               byp_nxt     = 1'b0;
      end
      SH_DR: begin
        if (sel_id) begin
          id_sr_nxt     = id_sr >> 1;
          id_sr_nxt[31] = TDI;
        end else if (sel_user) begin
          user_sr_nxt               = user_sr >> 1;
          user_sr_nxt[USER_WIDTH-1] = TDI;
        end else begin
          byp_nxt = TDI;
        end
      end
      default: ;
    endcase

    tdo_nxt = 1'b0;
    if (state_nxt == SH_IR) begin
      tdo_nxt = ir_sr_nxt[0];
    end else if (state_nxt == SH_DR) begin
      if (sel_id)        tdo_nxt = id_sr_nxt[0];
      else if (sel_user) tdo_nxt = user_sr_nxt[0];
      else               tdo_nxt = byp_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      state        <= TLR;
      ir_sr        <= '0;
      id_sr        <= '0;
      user_sr      <= '0;
      byp_sr       <= 1'b0;
      ir_out       <= IDCODE_IR;
      user_dr      <= '0;
      TDO          <= 1'b0;
      tdo_en       <= 1'b0;
      update_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      ir_sr        <= ir_sr_nxt;
      id_sr        <= id_sr_nxt;
      user_sr      <= user_sr_nxt;
      byp_sr       <= byp_nxt;
      TDO          <= tdo_nxt;
      tdo_en       <= (state_nxt == SH_DR) || (state_nxt == SH_IR);
      update_pulse <= (state == UPD_DR) && sel_user;
      if ((state == UPD_DR) && sel_user) user_dr <= user_sr;
      if (state == UPD_IR) ir_out <= ir_sr;
      // A TMS-driven walk into Test-Logic-Reset restores the default instruction.
      if (state_nxt == TLR) ir_out <= IDCODE_IR;
    end
  end

  assign state_obs = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: TAP walks, IR/DR scans, pause handling and TRST abort.
module tb_jtag_tap_ctrl;

  localparam int          IR_W   = 4;
  localparam int          USER_W = 8;
  localparam logic [31:0] IDVAL  = 32'h1000_0001;
  localparam int          ID_OP  = 1;
  localparam int          US_OP  = 2;

  logic              clk = 1'b0;
  logic              TRST = 1'b0;
  logic              TMS = 1'b1;
  logic              TDI = 1'b0;
  logic              TDO;
  logic              tdo_en;
  logic [3:0]        state_obs;
  logic [IR_W-1:0]   ir_out;
  logic [USER_W-1:0] user_dr;
  logic              update_pulse;

  int checks = 0;
  int errors = 0;

  jtag_tap_ctrl #(
    .IR_WIDTH(IR_W), .USER_WIDTH(USER_W), .IDCODE_VAL(IDVAL),
    .IDCODE_OP(ID_OP), .USER_OP(US_OP)
  ) dut (
    .clk(clk), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .state_obs(state_obs), .ir_out(ir_out), .user_dr(user_dr), .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_trst();
    TRST = 1'b1;
    tick(1'b0, 1'b0);
    TRST = 1'b0;
  endtask

  // From RTI: load an instruction, return the bits seen on TDO (first bit in [0]), end in RTI.
  task automatic ir_scan(input logic [IR_W-1:0] val, output logic [IR_W-1:0] tdo_bits);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++) begin
      tdo_bits[i] = TDO;
      tick(i == IR_W - 1, val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: n-bit DR scan; pulses = update_pulse in UpdDR, one cycle later, two cycles later.
  task automatic dr_scan(input int n, input logic [31:0] val, output logic [31:0] tdo_bits,
                         output logic [2:0] pulses);
    tdo_bits = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tdo_bits[i] = TDO;
      tick(i == n - 1, val[i]);
    end
    tick(1'b1, 1'b0);
    pulses[0] = update_pulse;
    tick(1'b0, 1'b0);
    pulses[1] = update_pulse;
    tick(1'b0, 1'b0);
    pulses[2] = update_pulse;
  endtask

  task automatic test_reset();
    TMS = 1'b1;
    do_trst();
    checks++;
    if (state_obs !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_obs);
    end
    checks++;
    if (ir_out !== IR_W'(ID_OP)) begin
      errors++; $display("[TB] FAIL reset_ir: got %0h expected %0h", ir_out, IR_W'(ID_OP));
    end
    checks++;
    if ({TDO, tdo_en, update_pulse} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_outs: got %b expected 000", {TDO, tdo_en, update_pulse});
    end
    checks++;
    if (user_dr !== '0) begin
      errors++; $display("[TB] FAIL reset_user: got %0h expected 0", user_dr);
    end
  endtask

  task automatic test_tms_reset();
    logic [7:0]      path [16];
    int              plen [16];
    logic [7:0]      p;
    logic [IR_W-1:0] dummy;
    path = '{8'b111, 8'b0, 8'b1, 8'b10, 8'b100, 8'b101, 8'b1010, 8'b10101,
             8'b1011, 8'b11, 8'b110, 8'b1100, 8'b1101, 8'b11010, 8'b110101, 8'b11011};
    plen = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
    for (int s = 0; s < 16; s++) begin
      do_trst();
      tick(1'b0, 1'b0);
      ir_scan(4'hF, dummy);
      p = path[s];
      for (int b = plen[s] - 1; b >= 0; b--) tick(p[b], 1'b0);
      checks++;
      if (state_obs !== 4'(s)) begin
        errors++; $display("[TB] FAIL walk_to_state: got %0d expected %0d", state_obs, s);
      end
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
      checks++;
      if (state_obs !== 4'd0) begin
        errors++; $display("[TB] FAIL tms_reset_state from %0d: got %0d expected 0", s, state_obs);
      end
      checks++;
      if (ir_out !== IR_W'(ID_OP)) begin
        errors++; $display("[TB] FAIL tms_reset_ir from %0d: got %0h expected %0h", s, ir_out, IR_W'(ID_OP));
      end
    end
  endtask

  task automatic test_idcode();
    logic [31:0] bits;
    do_trst();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if ({state_obs, tdo_en} !== {4'd4, 1'b1}) begin
      errors++; $display("[TB] FAIL idcode_enter_shift: got state %0d en %b expected 4 1", state_obs, tdo_en);
    end
    for (int i = 0; i < 32; i++) begin
      bits[i] = TDO;
      tick(i == 31, 1'b0);
    end
    checks++;
    if (bits !== IDVAL) begin
      errors++; $display("[TB] FAIL idcode_stream: got %h expected %h", bits, IDVAL);
    end
    checks++;
    if ({state_obs, tdo_en, TDO} !== {4'd5, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL idcode_exit: got state %0d en %b tdo %b expected 5 0 0", state_obs, tdo_en, TDO);
    end
  endtask

  task automatic test_ir_bypass();
    logic [IR_W-1:0] irbits;
    logic [31:0]     drbits;
    logic [2:0]      pulses;
    do_trst();
    tick(1'b0, 1'b0);
    ir_scan(4'hF, irbits);
    checks++;
    if (irbits !== 4'b0001) begin
      errors++; $display("[TB] FAIL ir_capture_bits: got %b expected 0001", irbits);
    end
    checks++;
    if (ir_out !== 4'hF) begin
      errors++; $display("[TB] FAIL ir_update: got %h expected f", ir_out);
    end
    dr_scan(8, 32'hA5, drbits, pulses);
    checks++;
    if (drbits[7:0] !== 8'h4A) begin
      errors++; $display("[TB] FAIL bypass_stream: got %h expected 4a", drbits[7:0]);
    end
    checks++;
    if ({pulses, user_dr} !== {3'b000, 8'h00}) begin
      errors++; $display("[TB] FAIL bypass_side_effects: got pulses %b user %h expected 000 00", pulses, user_dr);
    end
  endtask

  task automatic test_user();
    logic [IR_W-1:0] irbits;
    logic [31:0]     drbits;
    logic [2:0]      pulses;
    ir_scan(IR_W'(US_OP), irbits);
    checks++;
    if (ir_out !== IR_W'(US_OP)) begin
      errors++; $display("[TB] FAIL user_ir: got %h expected %h", ir_out, IR_W'(US_OP));
    end
    dr_scan(8, 32'h3C, drbits, pulses);
    checks++;
    if (drbits[7:0] !== 8'h00) begin
      errors++; $display("[TB] FAIL user_first_capture: got %h expected 00", drbits[7:0]);
    end
    checks++;
    if (user_dr !== 8'h3C) begin
      errors++; $display("[TB] FAIL user_load: got %h expected 3c", user_dr);
    end
    checks++;
    if (pulses !== 3'b010) begin
      errors++; $display("[TB] FAIL user_pulse: got %b expected 010", pulses);
    end
    dr_scan(8, 32'h81, drbits, pulses);
    checks++;
    if (drbits[7:0] !== 8'h3C) begin
      errors++; $display("[TB] FAIL user_recapture: got %h expected 3c", drbits[7:0]);
    end
    checks++;
    if (user_dr !== 8'h81) begin
      errors++; $display("[TB] FAIL user_reload: got %h expected 81", user_dr);
    end
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    checks++;
    if ({state_obs, ir_out, user_dr} !== {4'd0, IR_W'(ID_OP), 8'h81}) begin
      errors++; $display("[TB] FAIL tms_reset_keeps_user: got state %0d ir %h user %h expected 0 %h 81",
                         state_obs, ir_out, user_dr, IR_W'(ID_OP));
    end
  endtask

  task automatic test_pause();
    logic [IR_W-1:0] irbits;
    logic [7:0]      val;
    logic [7:0]      bits;
    int              bad_pause;
    val = 8'hC3;
    bad_pause = 0;
    tick(1'b0, 1'b0);
    ir_scan(IR_W'(US_OP), irbits);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bits[i] = TDO;
      tick(i == 3, val[i]);
    end
    tick(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if ({state_obs, tdo_en, TDO} !== {4'd6, 1'b0, 1'b0}) bad_pause++;
      tick(1'b0, 1'b0);
    end
    checks++;
    if (bad_pause !== 0) begin
      errors++; $display("[TB] FAIL pause_hold: got %0d bad cycles expected 0", bad_pause);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (state_obs !== 4'd4) begin
      errors++; $display("[TB] FAIL pause_resume_state: got %0d expected 4", state_obs);
    end
    for (int i = 4; i < 8; i++) begin
      bits[i] = TDO;
      tick(i == 7, val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (bits !== 8'h81) begin
      errors++; $display("[TB] FAIL pause_stream: got %h expected 81", bits);
    end
    checks++;
    if (user_dr !== 8'hC3) begin
      errors++; $display("[TB] FAIL pause_load: got %h expected c3", user_dr);
    end
  endtask

  task automatic test_trst_midshift();
    int pulses_seen;
    pulses_seen = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    checks++;
    if ({state_obs, tdo_en} !== {4'd4, 1'b1}) begin
      errors++; $display("[TB] FAIL midshift_setup: got state %0d en %b expected 4 1", state_obs, tdo_en);
    end
    TRST = 1'b1;
    tick(1'b0, 1'b1);
    TRST = 1'b0;
    checks++;
    if ({state_obs, tdo_en, TDO, update_pulse} !== {4'd0, 3'b000}) begin
      errors++; $display("[TB] FAIL trst_abort_outs: got state %0d en %b tdo %b pulse %b expected 0 0 0 0",
                         state_obs, tdo_en, TDO, update_pulse);
    end
    checks++;
    if ({ir_out, user_dr} !== {IR_W'(ID_OP), 8'h00}) begin
      errors++; $display("[TB] FAIL trst_abort_regs: got ir %h user %h expected %h 00",
                         ir_out, user_dr, IR_W'(ID_OP));
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0);
      if (update_pulse !== 1'b0) pulses_seen++;
    end
    checks++;
    if (pulses_seen !== 0) begin
      errors++; $display("[TB] FAIL trst_no_pulse: got %0d pulses expected 0", pulses_seen);
    end
  endtask

  initial begin
    test_reset();
    test_tms_reset();
    test_idcode();
    test_ir_bypass();
    test_user();
    test_pause();
    test_trst_midshift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
